mem_access_queue: RTL and testbench
===================================

Name: mem_access_queue

Overview:
- In-order load/store queue directly upstream of the word-addressed, multi-cycle data RAM in the Tomasulo core.
- Accepts memory operations from load/store reservation stations and issues them one at a time to the RAM.
- Holds address, data and the active-low request stable until the RAM raises its status flag.
- Returns load results on the CDB with a tag, and reports store completion.

Parameters:
- DEPTH, 4: queue entries (power of two, >=2).
- TAG_W, 4: reservation-station tag width.
- TIMEOUT, 32: cycle limit for one RAM operation (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  enqueue request.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_is_store  in  1  1 = store, 0 = load.
- in_tag  in  TAG_W  producer tag.
- in_addr  in  32  byte address.
- in_data  in  32  store data; ignored for loads.
- mem_addr  out  32  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_nRD  out  1  active-low RAM read request.
- mem_nWR  out  1  active-low RAM write request.
- mem_rdata  in  32  RAM read data.
- mem_readStatus  in  1  RAM read complete.
- mem_writeStatus  in  1  RAM write complete.
- cdb_req  out  1  load result pending on CDB.
- cdb_tag  out  TAG_W  tag of the pending load.
- cdb_data  out  32  load data.
- cdb_grant  in  1  CDB arbiter accepts the result this cycle.
- st_done  out  1  one-cycle pulse: head store finished.
- st_tag  out  TAG_W  tag of the finished store; valid while st_done=1.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, nRST=0): queue empty, count=0, state IDLE.
  - mem_nRD=1, mem_nWR=1; mem_addr=0, mem_wdata=0.
  - cdb_req=0, cdb_tag=0, cdb_data=0; st_done=0, st_tag=0.
  - Reset mid-operation abandons the in-flight op with no completion reported.
- Enqueue: when in_valid && in_ready, write {is_store, tag, addr, data} at the tail.
  - No enqueue when full: in_ready=0 and in_valid is ignored.
  - Enqueue and pop in the same cycle are allowed; count is unchanged.
- Ordering: strictly FIFO; only the head entry is ever issued.
- All RAM-side outputs are registered from posedge.
- FSM:
  - IDLE: if count>0, load mem_addr/mem_wdata from the head and drive mem_nRD=0 (load) or mem_nWR=0 (store); go to ISSUE.
  - ISSUE: hold all RAM outputs stable.
    - Load: on mem_readStatus=1, capture mem_rdata into cdb_data, cdb_tag=head tag, cdb_req=1, mem_nRD=1; go to BCAST.
    - Store: on mem_writeStatus=1, mem_nWR=1, st_done=1, st_tag=head tag, pop; go to IDLE.
  - BCAST: hold cdb_req/cdb_tag/cdb_data. On cdb_grant=1: cdb_req=0, pop, go to IDLE.
- Each completion is followed by at least one IDLE cycle with both requests high. This lets the RAM counter return to 0 before the next request.
- Status ignored outside ISSUE. Stale pulses after reset have no effect.
- Status of the other type is ignored, e.g. writeStatus during a load.
- Latency:
  - Entry enqueued into an empty queue at edge k: request asserted after edge k+1.
  - Load with RAM latency L cycles: cdb_req rises the edge after status is sampled.
- cdb_grant outside BCAST is ignored.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: MEMQ_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, reset 0).
  - A cycle counter runs in ISSUE. If status has not arrived after TIMEOUT cycles:
    - timeout_err is set (sticky until reset);
    - both requests deassert;
    - the head is popped without CDB/st_done;
    - FSM returns to IDLE.
- Not defined: no port, no counter; ISSUE waits indefinitely.

Test Plan:
- Single load, RAM model latency 10, ram[8..11]=0x11223344; enqueue load tag=3 addr=8 -> mem_nRD low after 1 cycle and held; cdb_req=1 with cdb_tag=3, cdb_data=0x11223344; mem_nRD=1 on the same edge.
- Store tag=5 addr=12 data=0xDEADBEEF then load tag=6 addr=12 -> st_done pulse with st_tag=5, then cdb_data=0xDEADBEEF tag=6; at least one IDLE gap with both requests high between the two ops.
- Fill DEPTH=4 loads with no grant -> in_ready=0, count=4, 5th in_valid dropped; grant each -> four results in order, count=0.
- Load in BCAST with cdb_grant held 0 for 7 cycles -> cdb_req/tag/data stable, no new RAM request; grant -> pop, next op issued.
- nRST asserted in ISSUE -> outputs at reset values immediately; later status pulse ignored; queue empty.
- With MEMQ_TIMEOUT_EN and RAM never responding -> after 32 ISSUE cycles timeout_err=1, mem_nRD=1, head dropped, next entry issued.

Source files
------------

// File: rtl/mem_access_queue.sv
// In-order load/store queue that issues one operation at a time to a multi-cycle data RAM.
// Define MEMQ_TIMEOUT_EN to add the per-operation watchdog and its sticky timeout_err output.
module mem_access_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_is_store,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [31:0]                in_addr,
    input  logic [31:0]                in_data,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       mem_nRD,
    output logic                       mem_nWR,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_readStatus,
    input  logic                       mem_writeStatus,
    output logic                       cdb_req,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [31:0]                cdb_data,
    input  logic                       cdb_grant,
    output logic                       st_done,
    output logic [TAG_W-1:0]           st_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef MEMQ_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BCAST = 2'd2;

    logic             q_store [DEPTH];
    logic [TAG_W-1:0] q_tag   [DEPTH];
    logic [31:0]      q_addr  [DEPTH];
    logic [31:0]      q_data  [DEPTH];

    logic [1:0]       state_q,     state_d;
    logic [PW-1:0]    head_q,      head_d;
    logic [PW-1:0]    tail_q,      tail_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [31:0]      mem_addr_q,  mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_nrd_q,   mem_nrd_d;
    logic             mem_nwr_q,   mem_nwr_d;
    logic             cdb_req_q,   cdb_req_d;
    logic [TAG_W-1:0] cdb_tag_q,   cdb_tag_d;
    logic [31:0]      cdb_data_q,  cdb_data_d;
    logic             st_done_q,   st_done_d;
    logic [TAG_W-1:0] st_tag_q,    st_tag_d;
    logic             push, pop;

`ifdef MEMQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0]    timer_q,     timer_d;
    logic             tmo_err_q,   tmo_err_d;
`endif

    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_nrd_d   = mem_nrd_q;
        mem_nwr_d   = mem_nwr_q;
        cdb_req_d   = cdb_req_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        st_done_d   = 1'b0;
        st_tag_d    = st_tag_q;
        pop         = 1'b0;
`ifdef MEMQ_TIMEOUT_EN
        timer_d     = timer_q;
        tmo_err_d   = tmo_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mem_addr_d  = q_addr[head_q];
                    mem_wdata_d = q_data[head_q];
                    if (q_store[head_q]) mem_nwr_d = 1'b0;
                    else                 mem_nrd_d = 1'b0;
                    state_d = ISSUE;
`ifdef MEMQ_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            ISSUE: begin
                // Only the status matching the head's operation type is honoured.
                if (!q_store[head_q] && mem_readStatus) begin
                    cdb_data_d = mem_rdata;
                    cdb_tag_d  = q_tag[head_q];
                    cdb_req_d  = 1'b1;
                    mem_nrd_d  = 1'b1;
                    state_d    = BCAST;
                end else if (q_store[head_q] && mem_writeStatus) begin
                    mem_nwr_d = 1'b1;
                    st_done_d = 1'b1;
                    st_tag_d  = q_tag[head_q];
                    pop       = 1'b1;
                    state_d   = IDLE;
                end
`ifdef MEMQ_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT-1)) begin
                    mem_nrd_d = 1'b1;
                    mem_nwr_d = 1'b1;
                    tmo_err_d = 1'b1;
                    pop       = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            BCAST: begin
                if (cdb_grant) begin
                    cdb_req_d = 1'b0;
                    pop       = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_nrd_q   <= 1'b1;
            mem_nwr_q   <= 1'b1;
            cdb_req_q   <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            st_done_q   <= 1'b0;
            st_tag_q    <= '0;
`ifdef MEMQ_TIMEOUT_EN
            timer_q     <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_nrd_q   <= mem_nrd_d;
            mem_nwr_q   <= mem_nwr_d;
            cdb_req_q   <= cdb_req_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            st_done_q   <= st_done_d;
            st_tag_q    <= st_tag_d;
`ifdef MEMQ_TIMEOUT_EN
            timer_q     <= timer_d;
            tmo_err_q   <= tmo_err_d;
`endif
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_store[tail_q] <= in_is_store;
            q_tag[tail_q]   <= in_tag;
            q_addr[tail_q]  <= in_addr;
            q_data[tail_q]  <= in_data;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_nRD   = mem_nrd_q;
    assign mem_nWR   = mem_nwr_q;
    assign cdb_req   = cdb_req_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign st_done   = st_done_q;
    assign st_tag    = st_tag_q;
    assign count     = count_q;
`ifdef MEMQ_TIMEOUT_EN
    assign timeout_err = tmo_err_q;
`endif

endmodule

// File: tb/tb_mem_access_queue.sv
// Directed bench for mem_access_queue with a small multi-cycle RAM model (latency 10).
// Define MEMQ_TIMEOUT_EN to also exercise the watchdog path.
module tb_mem_access_queue;

    logic        clk = 1'b0;
    logic        nRST;
    logic        in_valid, in_ready, in_is_store;
    logic [3:0]  in_tag;
    logic [31:0] in_addr, in_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_nRD, mem_nWR, mem_readStatus, mem_writeStatus;
    logic        cdb_req, cdb_grant, st_done;
    logic [3:0]  cdb_tag, st_tag;
    logic [31:0] cdb_data;
    logic [2:0]  count;
`ifdef MEMQ_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_queue #(.DEPTH(4), .TAG_W(4), .TIMEOUT(32)) dut (
        .clk(clk), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_tag(in_tag), .in_addr(in_addr), .in_data(in_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_nRD(mem_nRD), .mem_nWR(mem_nWR),
        .mem_rdata(mem_rdata), .mem_readStatus(mem_readStatus), .mem_writeStatus(mem_writeStatus),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant),
        .st_done(st_done), .st_tag(st_tag), .count(count)
`ifdef MEMQ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    // RAM model: status rises once a request has been held low for ram_lat edges.
    logic [31:0] ram [64];
    int unsigned ram_cnt = 0;
    int unsigned ram_lat = 10;
    logic        ram_on = 1'b1;
    logic        force_rd = 1'b0, force_wr = 1'b0;
    logic        model_rd, model_wr;

    assign model_rd        = ram_on && !mem_nRD && (ram_cnt >= ram_lat);
    assign model_wr        = ram_on && !mem_nWR && (ram_cnt >= ram_lat);
    assign mem_readStatus  = model_rd | force_rd;
    assign mem_writeStatus = model_wr | force_wr;
    assign mem_rdata       = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (!mem_nRD || !mem_nWR) ram_cnt <= ram_cnt + 1;
        else                      ram_cnt <= 0;
        if (model_wr) ram[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [3:0] tag, input logic [31:0] addr,
                        input logic [31:0] data);
        in_valid = 1'b1; in_is_store = st; in_tag = tag; in_addr = addr; in_data = data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_cdb(input string tag, output int n);
        n = 0;
        while (!cdb_req && n < 200) begin tick(); n++; end
        check(tag, {31'd0, cdb_req}, 32'd1);
    endtask

    task automatic wait_st(input string tag, output int n);
        n = 0;
        while (!st_done && n < 200) begin tick(); n++; end
        check(tag, {31'd0, st_done}, 32'd1);
    endtask

    task automatic grant();
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[2] = 32'h11223344;
        ram[4] = 32'hA0A0_0001; ram[5] = 32'hA1A1_0002;
        ram[6] = 32'hA2A2_0003; ram[7] = 32'hA3A3_0004;
        nRST = 1'b0; in_valid = 1'b0; in_is_store = 1'b0; in_tag = '0;
        in_addr = '0; in_data = '0; cdb_grant = 1'b0;
        #7;
        check("rst_nrd_nwr", {30'd0, mem_nRD, mem_nWR}, 32'd3);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cdb", {cdb_req, st_done, cdb_tag, st_tag}, 32'd0);
        check("rst_addr", mem_addr | mem_wdata | cdb_data, 32'd0);
`ifdef MEMQ_TIMEOUT_EN
        check("rst_tmo", {31'd0, timeout_err}, 32'd0);
`endif
        #5 nRST = 1'b1;
        tick();

        // single load
        push(1'b0, 4'd3, 32'd8, 32'd0);
        check("ld_nrd_wait", {31'd0, mem_nRD}, 32'd1);
        tick();
        check("ld_nrd_low", {31'd0, mem_nRD}, 32'd0);
        check("ld_addr", mem_addr, 32'd8);
        wait_cdb("ld_cdb_wait", n);
        check("ld_latency", n, 32'd11);
        check("ld_nrd_rel", {31'd0, mem_nRD}, 32'd1);
        check("ld_tag", {28'd0, cdb_tag}, 32'd3);
        check("ld_data", cdb_data, 32'h11223344);
        grant();
        check("ld_pop_req", {31'd0, cdb_req}, 32'd0);
        check("ld_pop_cnt", {29'd0, count}, 32'd0);

        // store then load to the same address
        push(1'b1, 4'd5, 32'd12, 32'hDEADBEEF);
        push(1'b0, 4'd6, 32'd12, 32'd0);
        check("st_nwr_low", {30'd0, mem_nRD, mem_nWR}, 32'd2);
        check("st_wdata", mem_wdata, 32'hDEADBEEF);
        wait_st("st_wait", n);
        check("st_tag", {28'd0, st_tag}, 32'd5);
        check("st_gap", {30'd0, mem_nRD, mem_nWR}, 32'd3);
        check("st_cnt", {29'd0, count}, 32'd1);
        tick();
        check("st_pulse", {31'd0, st_done}, 32'd0);
        check("ld2_nrd_low", {30'd0, mem_nRD, mem_nWR}, 32'd1);
        check("ld2_addr", mem_addr, 32'd12);
        wait_cdb("ld2_cdb_wait", n);
        check("ld2_tag", {28'd0, cdb_tag}, 32'd6);
        check("ld2_data", cdb_data, 32'hDEADBEEF);
        grant();

        // fill, overflow attempt, ordered drain with a stalled first grant
        for (int i = 0; i < 4; i++) push(1'b0, 4'(7 + i), 32'(16 + 4 * i), 32'd0);
        check("full_cnt", {29'd0, count}, 32'd4);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        push(1'b0, 4'd11, 32'd8, 32'd0);
        check("full_drop", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            wait_cdb("fill_cdb_wait", n);
            check("fill_tag", {28'd0, cdb_tag}, 32'(7 + i));
            check("fill_data", cdb_data, ram[4 + i]);
            if (i == 0) begin
                for (int c = 0; c < 7; c++) begin
                    tick();
                    check("hold_req", {31'd0, cdb_req}, 32'd1);
                    check("hold_tag", {28'd0, cdb_tag}, 32'd7);
                    check("hold_data", cdb_data, 32'hA0A0_0001);
                    check("hold_noreq", {30'd0, mem_nRD, mem_nWR}, 32'd3);
                end
            end
            grant();
            check("fill_pop_req", {31'd0, cdb_req}, 32'd0);
            check("fill_pop_cnt", {29'd0, count}, 32'(3 - i));
            if (i == 0) begin
                tick();
                check("fill_next_nrd", {31'd0, mem_nRD}, 32'd0);
                check("fill_next_addr", mem_addr, 32'd20);
            end
        end
        check("drain_ready", {31'd0, in_ready}, 32'd1);

        // reset while a load is in ISSUE
        push(1'b0, 4'd2, 32'd8, 32'd0);
        tick();
        check("rs_issue", {31'd0, mem_nRD}, 32'd0);
        nRST = 1'b0;
        #1;
        check("rs_nrd", {31'd0, mem_nRD}, 32'd1);
        check("rs_cnt", {29'd0, count}, 32'd0);
        check("rs_addr", mem_addr, 32'd0);
        #1 nRST = 1'b1;
        tick();
        force_rd = 1'b1; force_wr = 1'b1;
        tick();
        force_rd = 1'b0; force_wr = 1'b0;
        tick();
        check("rs_stale_cdb", {30'd0, cdb_req, st_done}, 32'd0);
        check("rs_stale_req", {30'd0, mem_nRD, mem_nWR}, 32'd3);
        check("rs_stale_cnt", {29'd0, count}, 32'd0);

`ifdef MEMQ_TIMEOUT_EN
        // RAM never answers: head dropped after 32 ISSUE cycles
        ram_on = 1'b0;
        push(1'b0, 4'd1, 32'd8, 32'd0);
        push(1'b0, 4'd4, 32'd12, 32'd0);
        check("to_nrd_low", {31'd0, mem_nRD}, 32'd0);
        n = 0;
        while (!timeout_err && n < 100) begin tick(); n++; end
        check("to_cycles", n, 32'd32);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_nrd_rel", {31'd0, mem_nRD}, 32'd1);
        check("to_cnt", {29'd0, count}, 32'd1);
        check("to_no_cdb", {31'd0, cdb_req}, 32'd0);
        tick();
        check("to_next_nrd", {31'd0, mem_nRD}, 32'd0);
        check("to_next_addr", mem_addr, 32'd12);
        ram_on = 1'b1;
        wait_cdb("to_cdb_wait", n);
        check("to_next_tag", {28'd0, cdb_tag}, 32'd4);
        check("to_sticky", {31'd0, timeout_err}, 32'd1);
        grant();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
